// File: rtl/pointwise_if.sv
// Pixel stream bundle: request/read-data toward the source, valid/write-data toward the sink.
// The master side is the pointwise kernel.
interface pointwise_if;
    logic        read_en;
    logic [15:0] read_data [0:0];
    logic        write_valid;
    logic [15:0] write_data [0:0];

    modport master (
        output read_en,
        input  read_data,
        output write_valid,
        output write_data
    );

    modport slave (
        input  read_en,
        output read_data,
        input  write_valid,
        input  write_data
    );
endinterface

// File: rtl/pointwise.sv
// Streaming pointwise kernel: reads one frame in raster order and emits 2*in two cycles later.
// Optional build macro POINTWISE_SATURATE_EN clamps the doubled value at 16'hFFFF instead of wrapping.
module pointwise #(
    parameter int unsigned IMG_WIDTH  = 64,
    parameter int unsigned IMG_HEIGHT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    output logic        hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en,
    input  logic [15:0] hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read [0:0],
    output logic        hw_output_stencil_op_hcompute_hw_output_stencil_write_valid,
    output logic [15:0] hw_output_stencil_op_hcompute_hw_output_stencil_write [0:0]
);

    localparam int unsigned XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [XW-1:0] XMax = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] YMax = YW'(IMG_HEIGHT - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          done_q, done_d;
    logic          v1_q, v1_d, v2_q, v2_d;
    logic [15:0]   d1_q, d1_d, d2_q, d2_d;

    logic          restart;
    logic          read_en;
    logic [15:0]   pix_in;
    logic [15:0]   pix_calc;

    // rst_n is active-high here; both reset and flush restart the schedule at pixel (0,0).
    assign restart = rst_n | flush;
    assign read_en = ~restart & ~done_q;
    assign pix_in  = hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read[0];

`ifdef POINTWISE_SATURATE_EN
    assign pix_calc = pix_in[15] ? 16'hFFFF : {pix_in[14:0], 1'b0};
`else
    assign pix_calc = {pix_in[14:0], 1'b0};
`endif

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        done_d = done_q;
        if (restart) begin
            x_d    = '0;
            y_d    = '0;
            done_d = 1'b0;
        end else if (read_en) begin
            if (x_q == XMax) begin
                x_d = '0;
                if (y_q == YMax) begin
                    y_d    = '0;
                    done_d = 1'b1;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_comb begin
        v1_d = read_en;
        d1_d = read_en ? pix_calc : 16'h0000;
        v2_d = v1_q & ~restart;
        d2_d = (v1_q & ~restart) ? d1_q : 16'h0000;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            done_q <= 1'b0;
            v1_q   <= 1'b0;
            d1_q   <= 16'h0000;
            v2_q   <= 1'b0;
            d2_q   <= 16'h0000;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            done_q <= done_d;
            v1_q   <= v1_d;
            d1_q   <= d1_d;
            v2_q   <= v2_d;
            d2_q   <= d2_d;
        end
    end

    // Outputs are masked combinationally so a reset/flush cycle never shows a stale pixel.
    always_comb begin
        hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en = read_en;
        hw_output_stencil_op_hcompute_hw_output_stencil_write_valid = v2_q & ~restart;
        hw_output_stencil_op_hcompute_hw_output_stencil_write[0] =
            (v2_q & ~restart) ? d2_q : 16'h0000;
    end

endmodule

// File: tb/tb_pointwise.sv
// Randomized directed bench for pointwise against a cycle-history reference model.
// Honours POINTWISE_SATURATE_EN for the expected arithmetic.
module tb_pointwise;

    localparam int N    = 64 * 64;
    localparam int MaxC = 20000;

    logic clk;
    logic rst_n;
    logic flush;

    pointwise_if pif ();

    pointwise #(
        .IMG_WIDTH  (64),
        .IMG_HEIGHT (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en (pif.read_en),
        .hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read    (pif.read_data),
        .hw_output_stencil_op_hcompute_hw_output_stencil_write_valid          (pif.write_valid),
        .hw_output_stencil_op_hcompute_hw_output_stencil_write                (pif.write_data)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    bit          hist_rd  [MaxC];
    logic [15:0] hist_val [MaxC];
    bit          hist_ab  [MaxC];

    int c          = 0;
    int pix_cnt    = 0;
    int checks     = 0;
    int errors     = 0;
    int frame_outs = 0;

    function automatic logic [15:0] ref_f(input logic [15:0] v);
        int p;
        p = 2 * int'(v);
`ifdef POINTWISE_SATURATE_EN
        if (p > 65535) p = 65535;
        return p[15:0];
`else
        p = p % 65536;
        return p[15:0];
`endif
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %h expected %h", tag, c, obs, exp);
        end
    endtask

    task automatic check_count(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, predict from history, sample mid-cycle, advance the model.
    task automatic cyc(input bit r, input bit f, input logic [15:0] din);
        bit          ab;
        bit          exp_re;
        bit          exp_wv;
        logic [15:0] exp_w;
        rst_n             = r;
        flush             = f;
        pif.read_data[0]  = din;
        ab                = r | f;
        exp_re            = !ab && (pix_cnt < N);
        hist_rd[c]        = exp_re;
        hist_val[c]       = din;
        hist_ab[c]        = ab;
        exp_wv            = 1'b0;
        exp_w             = 16'h0000;
        if (c >= 2) begin
            exp_wv = hist_rd[c-2] && !hist_ab[c-1] && !ab;
            if (exp_wv) exp_w = ref_f(hist_val[c-2]);
        end
        @(negedge clk);
        check("read_en", {15'b0, pif.read_en}, {15'b0, exp_re});
        check("write_valid", {15'b0, pif.write_valid}, {15'b0, exp_wv});
        check("write", pif.write_data[0], exp_w);
        if (pif.write_valid === 1'b1) frame_outs++;
        @(posedge clk);
        #1;
        if (ab) pix_cnt = 0;
        else if (exp_re) pix_cnt++;
        c++;
    endtask

    initial begin
        rst_n            = 1'b1;
        flush            = 1'b0;
        pif.read_data[0] = 16'h0000;

        // Reset, then ramp input 0,1,2,... over a full frame and a long idle tail.
        cyc(1'b1, 1'b0, 16'h0000);
        cyc(1'b1, 1'b0, 16'h0000);
        frame_outs = 0;
        for (int i = 0; i < N + 2; i++) cyc(1'b0, 1'b0, 16'(pix_cnt));
        for (int i = 0; i < 1000; i++) cyc(1'b0, 1'b0, 16'($urandom));
        check_count("ramp_frame_count", frame_outs, N);

        // Random frame with edge values, flushed at t=100.
        cyc(1'b1, 1'b0, 16'h0000);
        frame_outs = 0;
        for (int t = 0; t < 100; t++) begin
            if (t == 10)      cyc(1'b0, 1'b0, 16'h8001);
            else if (t == 11) cyc(1'b0, 1'b0, 16'hFFFF);
            else if (t == 12) cyc(1'b0, 1'b0, 16'h7FFF);
            else              cyc(1'b0, 1'b0, 16'($urandom));
        end
        cyc(1'b0, 1'b1, 16'($urandom));
        check_count("pre_flush_count", frame_outs, 98);
        frame_outs = 0;
        for (int i = 0; i < N + 3; i++) cyc(1'b0, 1'b0, 16'($urandom));
        check_count("post_flush_frame_count", frame_outs, N);

        // Reset and flush together at t=50 of a random frame.
        cyc(1'b1, 1'b0, 16'h0000);
        for (int t = 0; t < 50; t++) cyc(1'b0, 1'b0, 16'($urandom));
        cyc(1'b1, 1'b1, 16'($urandom));
        frame_outs = 0;
        for (int i = 0; i < N + 3; i++) cyc(1'b0, 1'b0, 16'($urandom));
        check_count("post_reset_frame_count", frame_outs, N);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
